// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B3 bundle of LANES parallel ports; lane k occupies [k*width +: width].
// Pure wiring: no state and no added latency.
// Stalls are expressed by withholding ack/err/rty; there is no separate ready.
interface wb_rr_arbiter_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned dw    = 32,
  parameter int unsigned aw    = 32
);
  // Request side, driven by the bus master(s)
  logic [LANES*aw-1:0] adr;
  logic [LANES*dw-1:0] wr_dat;
  logic [LANES*4-1:0]  sel;
  logic [LANES-1:0]    we;
  logic [LANES-1:0]    cyc;
  logic [LANES-1:0]    stb;
  logic [LANES*3-1:0]  cti;
  logic [LANES*2-1:0]  bte;
  // Response side, driven by the bus slave
  logic [LANES*dw-1:0] rd_dat;
  logic [LANES-1:0]    ack;
  logic [LANES-1:0]    err;
  logic [LANES-1:0]    rty;

  modport master (
    output adr, wr_dat, sel, we, cyc, stb, cti, bte,
    input  rd_dat, ack, err, rty
  );

  modport slave (
    input  adr, wr_dat, sel, we, cyc, stb, cti, bte,
    output rd_dat, ack, err, rty
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 round-robin arbiter with a hung-slave watchdog.
// Grant registered one edge after cyc; request/response paths are combinational.
// Slave stalls pass straight through; the watchdog ends a stall with ERR after TIMEOUT cycles.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_rr_arbiter_if.slave         m_bus,     // NUM_MASTERS lanes, faces the masters
  wb_rr_arbiter_if.master        s_bus,     // single lane, faces the shared slave
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  // TIMEOUT=0 disables the watchdog; keep the counter one bit wide in that case.
  localparam int unsigned WDT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);
  localparam logic [WDT_W-1:0] WDT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  // last_q doubles as the index of the current owner while a grant is held.
  logic [IDX_W-1:0]       last_q, last_d;
  logic [WDT_W-1:0]       wdt_q, wdt_d;

  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;
  logic [31:0]            g_lane;
  logic                   busy;
  logic                   in_err;
  logic                   term;
  logic                   stall;
  logic                   wdt_fire;

  assign busy     = |gnt_q;
  assign in_err   = (state_q == ST_ERR);
  assign g_lane   = 32'(last_q);
  assign term     = s_bus.ack[0] | s_bus.err[0] | s_bus.rty[0];
  // A stall is an outstanding strobe with no termination this cycle.
  assign stall    = (state_q == ST_GRANT) && s_bus.stb[0] && !term;
  // A termination in the expiry cycle clears stall, so the real response wins.
  assign wdt_fire = (TIMEOUT != 0) && stall && (wdt_q == WDT_LAST);

  assign grant_o   = gnt_q;
  assign timeout_o = in_err;

  // Round-robin search: first requester starting just above the previous winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      cand = IDX_W'((int'(last_q) + i) % int'(NUM_MASTERS));
      if (!win_vld && m_bus.cyc[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state logic: grant held for the whole cyc burst, no pre-emption.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d        = ST_GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          last_d         = win_idx;
        end
      end
      ST_GRANT: begin
        // Dropping cyc always returns to IDLE, which guarantees an idle cycle between owners.
        if (!m_bus.cyc[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (wdt_fire) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        // One-cycle error termination, then the owner may retry or release the bus.
        state_d = ST_GRANT;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Watchdog: counts consecutive stalled strobe cycles, saturating, cleared otherwise.
  always_comb begin
    wdt_d = '0;
    if (stall) begin
      if (wdt_q != WDT_MAX) begin
        wdt_d = wdt_q + 1'b1;
      end else begin
        wdt_d = wdt_q;
      end
    end
  end

  // State registers; reset restores master 0 as the first winner.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
    end
  end

  // Slave request mux: owner's signals when granted, all zero otherwise; strobe masked in ERR.
  always_comb begin
    s_bus.adr    = '0;
    s_bus.wr_dat = '0;
    s_bus.sel    = '0;
    s_bus.we     = '0;
    s_bus.cyc    = '0;
    s_bus.stb    = '0;
    s_bus.cti    = '0;
    s_bus.bte    = '0;
    if (busy) begin
      s_bus.adr    = m_bus.adr[g_lane*aw +: aw];
      s_bus.wr_dat = m_bus.wr_dat[g_lane*dw +: dw];
      s_bus.sel    = m_bus.sel[g_lane*4 +: 4];
      s_bus.we[0]  = m_bus.we[last_q];
      s_bus.cyc[0] = m_bus.cyc[last_q];
      s_bus.stb[0] = m_bus.stb[last_q] & ~in_err;
      s_bus.cti    = m_bus.cti[g_lane*3 +: 3];
      s_bus.bte    = m_bus.bte[g_lane*2 +: 2];
    end
  end

  // Response fan-out: terminations only to the owner, read data broadcast while granted.
  always_comb begin
    m_bus.ack    = '0;
    m_bus.err    = '0;
    m_bus.rty    = '0;
    m_bus.rd_dat = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      m_bus.ack[k] = gnt_q[k] & s_bus.ack[0] & ~in_err;
      m_bus.rty[k] = gnt_q[k] & s_bus.rty[0] & ~in_err;
      m_bus.err[k] = gnt_q[k] & (s_bus.err[0] | in_err);
      m_bus.rd_dat[k*dw +: dw] = busy ? s_bus.rd_dat : '0;
    end
  end

endmodule
